// File: rtl/bcd_convert_sequencer_pkg.sv
// Shared types and constants for the binary-to-BCD conversion sequencer.
package bcd_convert_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Bit counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_convert_sequencer_if.sv
// Request/result bundle between two requesters and the shared BCD converter.
interface bcd_convert_sequencer_if
  import bcd_convert_sequencer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic [1:0]                    req_vld;
  logic [2*WIDTH-1:0]            req_dat;
  logic [1:0]                    req_rdy;
  logic                          busy;
  logic                          result_vld;
  logic [BCD_DIGIT_W*DIGITS-1:0] result_bcd;
  logic                          result_id;

  modport master (
    output req_vld, req_dat,
    input  req_rdy, busy, result_vld, result_bcd, result_id
  );

  modport slave (
    input  req_vld, req_dat,
    output req_rdy, busy, result_vld, result_bcd, result_id
  );

endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: per-digit add-3 on digits >= 5, then shift left pulling in one operand bit.
// Purely combinational, no handshake.
module bcd_dabble_step
  import bcd_convert_sequencer_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  input  logic                          shift_in,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int BW = BCD_DIGIT_W * DIGITS;

  logic [BW-1:0] adj;

  always_comb begin
    adj = bcd_in;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_DIGIT_W'(ADD3_THRESH))
        adj[d*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_in[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
    end
  end

  // Top bit of adj falls off; it is always 0 when 10^DIGITS > 2^WIDTH-1.
  assign bcd_out = (adj << 1) | BW'(shift_in);

endmodule

// File: rtl/bcd_convert_sequencer.sv
// Round-robin shared binary-to-BCD converter: result pulse WIDTH+1 cycles after the accept cycle.
// Accepts only in IDLE (req_rdy low otherwise); no back-pressure on results.
module bcd_convert_sequencer
  import bcd_convert_sequencer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_convert_sequencer_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam int BW = BCD_DIGIT_W * DIGITS;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] opnd;
  logic [BW-1:0]  scratch, scratch_step;
  logic [CW-1:0]  cnt;
  logic           owner;
  logic           rr_ptr;
  logic [1:0]     grant;
  logic [1:0]     rdy;
  logic           xfer;
  logic           xfer_id;
  logic [WIDTH-1:0] xfer_dat;
  logic [BW-1:0]  result_bcd_q;
  logic           result_id_q;

  // rr_ptr names the requester that wins a tie.
  always_comb begin
    grant = 2'b00;
    if (bus.req_vld == 2'b11)
      grant = rr_ptr ? 2'b10 : 2'b01;
    else
      grant = bus.req_vld;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 2'b00;
    case (state)
      ST_IDLE: begin
        rdy = grant;
        if (|grant) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: if (cnt == CW'(1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (rst) rdy = 2'b00;
  end

  assign xfer     = (state == ST_IDLE) && (|grant);
  assign xfer_id  = grant[1];
  assign xfer_dat = xfer_id ? bus.req_dat[2*WIDTH-1:WIDTH] : bus.req_dat[WIDTH-1:0];

  bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
    .bcd_in   (scratch),
    .shift_in (opnd[WIDTH-1]),
    .bcd_out  (scratch_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      opnd         <= '0;
      scratch      <= '0;
      cnt          <= '0;
      owner        <= 1'b0;
      rr_ptr       <= 1'b0;
      result_bcd_q <= '0;
      result_id_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            opnd    <= xfer_dat;
            scratch <= '0;
            owner   <= xfer_id;
            cnt     <= CW'(WIDTH);
            rr_ptr  <= ~xfer_id;
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_step;
          opnd    <= opnd << 1;
          cnt     <= cnt - 1'b1;
          // Final iteration: publish so the result is stable during the DONE pulse.
          if (cnt == CW'(1)) begin
            result_bcd_q <= scratch_step;
            result_id_q  <= owner;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_rdy    = rdy;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.result_vld = (state == ST_DONE);
  assign bus.result_bcd = result_bcd_q;
  assign bus.result_id  = result_id_q;

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Scoreboard bench for bcd_convert_sequencer: randomized requests against a decimal-split reference model.
module tb_bcd_convert_sequencer;
  import bcd_convert_sequencer_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_convert_sequencer_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_convert_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          id;
    logic [BW-1:0] bcd;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   pend0[$];
  int   pend1[$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic gaps       = 1'b0;
  logic fill_fixed = 1'b0;

  // Reference-model state
  logic          last_served = 1'b1;
  int            next_free   = 0;
  logic [BW-1:0] last_bcd    = '0;
  logic          last_id     = 1'b0;

  function automatic logic [BW-1:0] ref_bcd(input int v);
    logic [BW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Driver: presents the head of each requester's queue, random data otherwise.
  initial begin
    bus.req_vld = '0;
    bus.req_dat = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        logic have;
        int   v;
        have = (i == 0) ? (pend0.size() > 0) : (pend1.size() > 0);
        v    = 0;
        if (have) v = (i == 0) ? pend0[0] : pend1[0];
        if (have && (!gaps || $urandom_range(3) != 0)) begin
          bus.req_vld[i]                 = 1'b1;
          bus.req_dat[i*WIDTH +: WIDTH]  = WIDTH'(v);
        end else begin
          bus.req_vld[i]                 = 1'b0;
          bus.req_dat[i*WIDTH +: WIDTH]  = fill_fixed ? WIDTH'(33) : WIDTH'($urandom);
        end
      end
    end
  end

  // Monitor + reference model, sampled on the falling edge.
  always @(negedge clk) begin
    logic       exp_vld;
    logic [1:0] exp_rdy;
    exp_t       e;
    int         v;
    exp_vld = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("result_vld", 32'(bus.result_vld), 32'(exp_vld));
    if (exp_vld) begin
      e = exp_q.pop_front();
      last_bcd = e.bcd;
      last_id  = e.id;
    end
    check("result_bcd", 32'(bus.result_bcd), 32'(last_bcd));
    check("result_id", 32'(bus.result_id), 32'(last_id));
    check("busy", 32'(bus.busy), 32'(cyc < next_free));

    exp_rdy = 2'b00;
    if (!rst && cyc >= next_free) begin
      if (bus.req_vld == 2'b11) exp_rdy = last_served ? 2'b01 : 2'b10;
      else                      exp_rdy = bus.req_vld;
    end
    check("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));

    if (rst) begin
      exp_q.delete();
      last_served = 1'b1;
      next_free   = 0;
      last_bcd    = '0;
      last_id     = 1'b0;
    end else if (exp_rdy != 2'b00) begin
      if (exp_rdy[1]) v = (pend1.size() > 0) ? pend1.pop_front() : 0;
      else            v = (pend0.size() > 0) ? pend0.pop_front() : 0;
      e.id  = exp_rdy[1];
      e.bcd = ref_bcd(v);
      e.due = cyc + WIDTH + 1;
      exp_q.push_back(e);
      last_served = exp_rdy[1];
      next_free   = cyc + WIDTH + 2;
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || exp_q.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n >= budget), 32'(0));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single request from requester 0
    pend0.push_back(255);
    wait_drain("single", 100);

    // Back-to-back from requester 1
    pend1.push_back(0);
    pend1.push_back(99);
    pend1.push_back(100);
    wait_drain("b2b", 100);

    // Both valid continuously: grants must alternate
    for (int k = 0; k < 3; k++) begin
      pend0.push_back(7);
      pend1.push_back(200);
    end
    wait_drain("rr", 200);

    // Reset during a conversion aborts it
    pend0.push_back(123);
    n = 0;
    while (pend0.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("abort_accept_timeout", 32'(n >= 50), 32'(0));
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pend0.push_back(45);
    wait_drain("post_reset", 100);

    // Operand changes after acceptance must not matter
    fill_fixed = 1'b1;
    pend0.push_back(150);
    wait_drain("hold", 100);
    fill_fixed = 1'b0;

    // Exhaustive sweep on alternating requesters with random valid gaps
    gaps = 1'b1;
    for (int v = 0; v < 256; v++) begin
      if (v % 2 == 0) pend0.push_back(v);
      else            pend1.push_back(v);
    end
    wait_drain("sweep", 8000);

    // Random traffic
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(1) == 0) pend0.push_back(int'($urandom_range(255)));
      else                        pend1.push_back(int'($urandom_range(255)));
    end
    wait_drain("random", 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_convert_sequencer.md
# bcd_convert_sequencer

Sequential binary-to-BCD conversion engine shared between two requesters (e.g. the LFSR output path and the seed/setting display path). A round-robin arbiter grants one requester at a time. It performs an iterative shift-add-3 (double-dabble) conversion over WIDTH cycles and presents a packed BCD result tagged with the requester ID for the seven-segment display path.

## Interface
Parameters:
- WIDTH, 8, binary operand width.
- DIGITS, 3, BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- Clock  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- ReqValid  in  2  per-requester request; bit i is requester i.
- ReqData  in  2*WIDTH  operands; requester i at [i*WIDTH +: WIDTH].
- ReqReady  out  2  per-requester accept strobe, at most one bit high.
- Busy  out  1  high while a conversion is in progress (SHIFT or DONE).
- ResultValid  out  1  one-cycle pulse when ResultBCD/ResultId update.
- ResultBCD  out  4*DIGITS  packed BCD, most significant digit at top nibble.
- ResultId  out  1  requester that owns ResultBCD.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ReqReady[i] = grant[i], combinational from ReqValid and the RR pointer. Forced 0 when Reset=1 or state≠IDLE.
  - Transfer occurs when ReqValid[i] & ReqReady[i].
  - On transfer: capture ReqData slice into the shift register, clear the BCD scratch register, latch the requester id, set bit counter to WIDTH, go to SHIFT.
- SHIFT:
  - Each cycle, every scratch digit ≥5 gets +3 (4-bit, no carry into neighbour).
  - Then shift {scratch, operand} left by 1.
  - Counter decrements; on the cycle it reaches 0, go to DONE.
- DONE:
  - Load ResultBCD from scratch and ResultId from latched id.
  - Pulse ResultValid for that cycle, then return to IDLE.
- Arbitration: round-robin.
  - If both requesters are valid, grant the one not served last.
  - If only one is valid, grant it regardless of the pointer.
  - Pointer updates only on a transfer. After reset, requester 0 has priority.
- ResultBCD/ResultId hold between pulses. There is no result back-pressure; consumers must sample on ResultValid.
- ReqValid dropping without a transfer is legal; no state change.
- ReqData is sampled only at the transfer edge; later changes do not affect the conversion in flight.

## Timing
- Reset values: state IDLE, Busy 0, ResultValid 0, ResultBCD 0, ResultId 0, RR pointer favours requester 0, ReqReady 0 while Reset=1.
- Transfer at edge T0; Busy high from T0+1; SHIFT occupies WIDTH cycles.
- ResultValid high in cycle T0+WIDTH+1 (cycle 9 for WIDTH=8); IDLE again at T0+WIDTH+2.
- Minimum spacing between transfers: WIDTH+2 cycles (10).
- A new request can be accepted in the first IDLE cycle after DONE.
- Reset asserted mid-conversion aborts the conversion on that edge: no ResultValid, outputs return to reset values.
- Requests arriving during SHIFT/DONE wait, with ReqReady low.

## Structure
- Shared package holds:
  - state enum (IDLE, SHIFT, DONE)
  - BCD digit width constant (4)
  - add-3 threshold constant (5)
  - a function computing counter width ($clog2(WIDTH+1))
- Sub-module bcd_dabble_step: purely combinational single iteration (per-digit adjust then 1-bit shift), parameterised by DIGITS. It is instantiated once; the sequencer owns all registers, the FSM and the arbiter.

## Test plan
- Requester 0 sends 255, requester 1 idle -> ReqReady[0] one cycle; ResultValid 9 cycles later; ResultBCD=0x255, ResultId=0.
- Back-to-back singles 0, 99, 100 from requester 1 -> results 0x000, 0x099, 0x100, each with ResultId=1, pulses 10 cycles apart.
- Both valid continuously with data 7 / 200 -> grants alternate 0,1,0,1; results 0x007/0x200 with matching ResultId; never both ReqReady high.
- Reset asserted 4 cycles into a conversion of 123 -> no ResultValid, outputs zero next cycle; the next request (45) yields 0x045 with ResultId 0.
- ReqData changed during SHIFT (150 -> 33) -> result still 0x150; exhaustive sweep 0..255 on alternating requesters matches the reference decimal split.
